alu_cmd_sequencer: RTL

- Sequential front end that feeds the team's combinational 4-bit ALU, which takes an 8-bit `sel` plus 4-bit `a` and `b` operands.
- Accepts packed instruction words over a valid/ready handshake and screens them before issue:
  - divide or modulo by zero is never issued to the ALU;
  - opcodes above 0x19 are never issued, so the ALU's default branch (`$display`) is never reached.
- Drives the ALU from registers, captures its result, and returns it with status over a second valid/ready handshake.
- Sits between the command source (testbench or controller) and the ALU instance.

---
 rtl/alu_cmd_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: registered front end for the combinational 4-bit ALU.
// Accepts packed instruction words, screens out illegal opcodes and
// divide/modulo by zero, drives the ALU from registers for one cycle,
// captures the result and returns it with status.
//
// Handshake rule (both ports): a transfer happens at a rising clk edge where
// valid and ready are both 1. The producer holds valid and data stable until
// that edge. The consumer may move ready freely. in_ready and out_valid are
// registered outputs of this block.
module alu_cmd_sequencer #(
  parameter int unsigned         DW     = 4,
  parameter int unsigned         OPW    = 8,
  parameter logic [OPW-1:0]      MAX_OP = 8'h19,
  parameter int unsigned         CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  // command input
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW+2*DW-1:0]    in_instr,
  // ALU drive / return
  output logic [OPW-1:0]         alu_sel,
  output logic [DW-1:0]          alu_a,
  output logic [DW-1:0]          alu_b,
  input  logic [DW-1:0]          alu_result,
  // result output
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_result,
  output logic [OPW-1:0]         out_opcode,
  output logic                   out_err,
  output logic [1:0]             out_err_code,
  output logic [CNT_W-1:0]       done_count,
  // debug view of the FSM state (0 IDLE, 1 EXEC, 2 DONE)
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [OPW-1:0] OP_DIV   = OPW'(8'h01);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(8'h02);
  localparam logic [OPW-1:0] OP_MOD   = OPW'(8'h04);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_DIVZERO  = 2'b10;

  state_t              state_q,        state_d;
  logic                in_ready_q,     in_ready_d;
  logic                out_valid_q,    out_valid_d;
  logic [DW-1:0]       out_result_q,   out_result_d;
  logic [OPW-1:0]      out_opcode_q,   out_opcode_d;
  logic                out_err_q,      out_err_d;
  logic [1:0]          out_err_code_q, out_err_code_d;
  logic [CNT_W-1:0]    done_count_q,   done_count_d;
  logic [OPW-1:0]      alu_sel_q,      alu_sel_d;
  logic [DW-1:0]       alu_a_q,        alu_a_d;
  logic [DW-1:0]       alu_b_q,        alu_b_d;

  // Instruction fields: [OPW+2*DW-1 : 2*DW] opcode, then a, then b.
  logic [OPW-1:0]      instr_op;
  logic [DW-1:0]       instr_a;
  logic [DW-1:0]       instr_b;
  logic                accept;
  logic                op_illegal;
  logic                op_divzero;

  // Field split and screening of the word currently presented.
  always_comb begin
    instr_op   = in_instr[OPW+2*DW-1 -: OPW];
    instr_a    = in_instr[2*DW-1 -: DW];
    instr_b    = in_instr[DW-1:0];
    accept     = in_valid & in_ready_q;
    op_illegal = (instr_op > MAX_OP);
    op_divzero = ((instr_op == OP_DIV) || (instr_op == OP_MOD)) &&
                 (instr_b == '0);
  end

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_opcode_d   = out_opcode_q;
    out_err_d      = out_err_q;
    out_err_code_d = out_err_code_q;
    done_count_d   = done_count_q;
    alu_sel_d      = alu_sel_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          out_opcode_d = instr_op;
          in_ready_d   = 1'b0;
          if (op_illegal) begin
            // Never reaches the ALU; its default branch stays unexercised.
            out_err_d      = 1'b1;
            out_err_code_d = ERR_ILLEGAL;
            out_result_d   = '0;
            out_valid_d    = 1'b1;
            state_d        = DONE;
          end else if (op_divzero) begin
            out_err_d      = 1'b1;
            out_err_code_d = ERR_DIVZERO;
            out_result_d   = '0;
            out_valid_d    = 1'b1;
            state_d        = DONE;
          end else begin
            alu_sel_d      = instr_op;
            alu_a_d        = instr_a;
            alu_b_d        = instr_b;
            out_err_d      = 1'b0;
            out_err_code_d = ERR_NONE;
            state_d        = EXEC;
          end
        end
      end

      EXEC: begin
        // ALU inputs have been stable for this whole cycle; take the result.
        out_result_d = alu_result;
        out_valid_d  = 1'b1;
        state_d      = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
          if (done_count_q != {CNT_W{1'b1}}) begin
            done_count_d = done_count_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Single register bank for the FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_opcode_q   <= '0;
      out_err_q      <= 1'b0;
      out_err_code_q <= ERR_NONE;
      done_count_q   <= '0;
      alu_sel_q      <= OP_ADD;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_opcode_q   <= out_opcode_d;
      out_err_q      <= out_err_d;
      out_err_code_q <= out_err_code_d;
      done_count_q   <= done_count_d;
      alu_sel_q      <= alu_sel_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_opcode   = out_opcode_q;
  assign out_err      = out_err_q;
  assign out_err_code = out_err_code_q;
  assign done_count   = done_count_q;
  assign alu_sel      = alu_sel_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign dbg_state    = state_q;

endmodule
